mem_responder: RTL and testbench

Word-wide data-memory responder serving load/store requests from the processor datapath over a req/ack handshake. It holds a DEPTH-word RAM and answers each access after a fixed, programmable number of wait states. Misaligned and out-of-range accesses are flagged with an error response. It is the memory end of the processor's data-access interface and lets the datapath be exercised against slow memory rather than a zero-latency array.

---
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-wide data-memory responder: req/ack handshake, fixed wait states,
// error response for misaligned or out-of-range accesses.
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_capture;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic          w_enter_resp;
  logic          w_acc_we;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [31:0]   w_hi;
  logic          w_valid;
  logic [AW-1:0] w_index;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_capture = 1'b1;
          if (WAIT_STATES == 0) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered straight from IDLE, on the same
  // edge that captures the request, so the live inputs are used there.
  assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);
  assign w_acc_we     = (r_state == S_IDLE) ? we    : r_we;
  assign w_acc_addr   = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_acc_wdata  = (r_state == S_IDLE) ? wdata : r_wdata;
  assign w_hi         = w_acc_addr >> (AW + 2);
  assign w_valid      = (w_acc_addr[1:0] == 2'b00) && (w_hi == 32'd0);
  assign w_index      = w_acc_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ack   <= w_enter_resp;
      r_err   <= w_enter_resp && !w_valid;
      if (w_enter_resp) begin
        r_rdata <= (w_valid && !w_acc_we) ? r_mem[w_index] : 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  // Reset has priority over a store committing on the same edge.
  always_ff @(posedge clk) begin
    if (reset && w_enter_resp && w_valid && w_acc_we) begin
      r_mem[w_index] <= w_acc_wdata;
    end
  end

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign err   = r_err;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states, one with none;
// expected responses are queued at issue and popped when ack appears.
module tb_mem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        req2, we2, ack2, err2, busy2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        req0, we0, ack0, err0, busy0;
  logic [31:0] addr0, wdata0, rdata0;

  exp_t q2[$];
  exp_t q0[$];
  int   n_vec = 0;
  int   n_bad = 0;

  mem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .ack(ack2), .err(err2), .busy(busy2)
  );

  mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_chk2();
    exp_t e;
    if (q2.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_ack2: got ack, expected none");
    end else begin
      e = q2.pop_front();
      chk("rdata2", rdata2, e.rdata);
      chk("err2", 32'(err2), 32'(e.err));
    end
  endtask

  task automatic pop_chk0();
    exp_t e;
    if (q0.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_ack0: got ack, expected none");
    end else begin
      e = q0.pop_front();
      chk("rdata0", rdata0, e.rdata);
      chk("err0", 32'(err0), 32'(e.err));
    end
  endtask

  // Called just after an edge with the block in IDLE.
  task automatic access2(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic ee, input bit churn);
    int cyc;
    bit got;
    req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
    q2.push_back(exp_t'{rdata: er, err: ee});
    @(posedge clk); #1;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc <= 12) begin
      if (ack2) begin
        got = 1'b1;
      end else begin
        chk("busy_wait", 32'(busy2), 32'd1);
        if (churn) begin
          addr2  = $urandom;
          wdata2 = $urandom;
          we2    = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL ack_timeout: got no ack in %0d cycles, expected ack at 3", cyc);
      if (q2.size() > 0) void'(q2.pop_front());
    end else begin
      $display("acc we=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
               w, a, d, rdata2, err2, cyc);
      pop_chk2();
      chk("latency", 32'(cyc), 32'd3);
      @(posedge clk); #1;
      chk("busy_after_resp", 32'(busy2), 32'd0);
    end
    req2 = 1'b0;
    we2  = 1'b0;
  endtask

  vec_t tbl[12];
  vec_t v0[8];

  initial begin
    int gap;
    bit got;
    reset = 1'b0;
    req2 = 0; we2 = 0; addr2 = 0; wdata2 = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;

    tbl[0]  = '{1'b1, 32'h0000_0000, 32'hA5A5_0001, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 32'h0000_03FC, 32'hDEAD_BEEF, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_03FC, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0402, 32'h1111_1111, 32'h0, 1'b1};
    tbl[4]  = '{1'b1, 32'h0000_0400, 32'h2222_2222, 32'h0, 1'b1};
    tbl[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0001, 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_03FC, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_0401, 32'h0,         32'h0, 1'b1};
    tbl[8]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0, 1'b1};
    tbl[9]  = '{1'b1, 32'h0000_0004, 32'h1111_2222, 32'h0, 1'b0};
    tbl[10] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1111_2222, 1'b0};
    tbl[11] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      v0[i]     = '{1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 32'h0, 1'b0};
      v0[i + 4] = '{1'b0, 32'(i * 4), 32'h0, 32'hC0DE_0000 + 32'(i), 1'b0};
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_ack", 32'(ack2), 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_rdata", rdata2, 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);

    for (int i = 0; i < 12; i++) begin
      access2(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err, 1'b0);
    end

    // Reset again, then load: RAM survives, latency and busy checked in access2
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst2_rdata", rdata2, 32'd0);
    access2(1'b0, 32'h0, 32'h0, 32'hA5A5_0001, 1'b0, 1'b0);

    // Inputs churn while the store waits
    access2(1'b1, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
    access2(1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 1'b0);

    // Reset during WAIT of a store
    access2(1'b1, 32'h20, 32'hCAFE_0001, 32'h0, 1'b0, 1'b0);
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; wdata2 = 32'h0BAD_0020;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    req2 = 1'b0; we2 = 1'b0;
    chk("midrst_busy", 32'(busy2), 32'd0);
    chk("midrst_ack", 32'(ack2), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_ack", 32'(ack2), 32'd0);
    end
    access2(1'b0, 32'h20, 32'h0, 32'hCAFE_0001, 1'b0, 1'b0);

    // Reset on the very edge that would enter RESP of a store
    access2(1'b1, 32'h24, 32'h0000_0077, 32'h0, 1'b0, 1'b0);
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h24; wdata2 = 32'h0BAD_0024;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    req2 = 1'b0; we2 = 1'b0;
    chk("resprst_ack", 32'(ack2), 32'd0);
    chk("resprst_busy", 32'(busy2), 32'd0);
    access2(1'b0, 32'h24, 32'h0, 32'h0000_0077, 1'b0, 1'b0);
    access2(1'b0, 32'h3FC, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Zero wait states, req held continuously: four stores then four loads
    req0 = 1'b1; we0 = v0[0].we; addr0 = v0[0].addr; wdata0 = v0[0].wdata;
    q0.push_back(exp_t'{rdata: v0[0].exp_rdata, err: v0[0].exp_err});
    for (int i = 0; i < 8; i++) begin
      got = 1'b0;
      gap = 0;
      while (!got && gap < 6) begin
        @(posedge clk); #1;
        gap++;
        if (ack0) got = 1'b1;
      end
      if (!got) begin
        n_vec++;
        n_bad++;
        $display("FAIL b2b_timeout: got no ack for item %0d, expected one", i);
        break;
      end
      $display("b2b we=%0d addr=%08h -> rdata=%08h err=%0d gap=%0d",
               v0[i].we, v0[i].addr, rdata0, err0, gap);
      pop_chk0();
      chk("b2b_gap", 32'(gap), (i == 0) ? 32'd1 : 32'd2);
      if (i < 7) begin
        we0 = v0[i + 1].we; addr0 = v0[i + 1].addr; wdata0 = v0[i + 1].wdata;
        q0.push_back(exp_t'{rdata: v0[i + 1].exp_rdata, err: v0[i + 1].exp_err});
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    chk("b2b_idle_busy", 32'(busy0), 32'd0);

    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("q0_drained", 32'(q0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
